// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the
// serial packed-BCD adder.
package bcd_pkg;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         DIGIT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A nibble is a legal BCD digit when it does not exceed 9.
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_pair_add.sv
// Combinational two-digit BCD adder: adds two packed BCD pairs plus a
// decimal carry-in and produces a packed BCD pair and decimal carry-out.
// Non-BCD inputs give a well-defined but meaningless result; the
// controller flags and suppresses those cases.
module bcd_pair_add
    import bcd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // One decimal digit stage; returns {carry, digit}.
    function automatic logic [4:0] digit_add(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        logic [4:0] raw;
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (raw > {1'b0, BCD_DIGIT_MAX}) begin
            digit_add = {1'b1, 4'(raw - 5'd10)};
        end else begin
            digit_add = raw;
        end
    endfunction

    logic [4:0] lo_res;
    logic [4:0] hi_res;

    // Ripple the decimal carry from the low digit into the high digit.
    always_comb begin
        lo_res = digit_add(a[3:0], b[3:0], cin);
        hi_res = digit_add(a[7:4], b[7:4], lo_res[4]);
        sum    = {hi_res[3:0], lo_res[3:0]};
        cout   = hi_res[4];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-cycle controller that adds two DIGITS-wide packed-BCD operands by
// streaming them, one digit pair per cycle (LS pair first), through a
// single two-digit BCD adder with the decimal carry held between cycles.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic [4*DIGITS-1:0]     a_in,
    input  logic [4*DIGITS-1:0]     b_in,
    input  logic                    cin_in,
    output logic                    ready_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [4*DIGITS-1:0]     sum_out,
    output logic                    cout_out,
    output logic                    err_out
);

    localparam int PAIRS = DIGITS / 2;
    localparam int IDXW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int W     = DIGIT_W * DIGITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PAIRS - 1);

    state_t          state;
    state_t          state_next;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    res_sr;
    logic            carry;
    logic            err_sticky;

    logic [7:0]      pair_sum;
    logic            pair_cout;
    logic            pair_err;
    logic [W+7:0]    res_cat;
    logic [W-1:0]    res_next;
    logic            last_pair;
    logic            finish;

    bcd_pair_add u_pair_add (
        .a    (a_sr[7:0]),
        .b    (b_sr[7:0]),
        .cin  (carry),
        .sum  (pair_sum),
        .cout (pair_cout)
    );

    // New pair enters at the top of the result register so that after
    // PAIRS shifts pair 0 sits in the least-significant byte.
    assign res_cat  = {pair_sum, res_sr};
    assign res_next = res_cat[W+7:8];

    assign pair_err = !is_bcd_digit(a_sr[3:0]) || !is_bcd_digit(a_sr[7:4]) ||
                      !is_bcd_digit(b_sr[3:0]) || !is_bcd_digit(b_sr[7:4]);

    assign last_pair = (idx == LAST_IDX);
    // Abort takes priority over completing the final pair.
    assign finish    = (state == RUN) && !abort_in && last_pair;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        ready_out  = 1'b0;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        unique case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (start_in) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_out = 1'b1;
                if (abort_in) begin
                    state_next = IDLE;
                end else if (last_pair) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry, sticky error and pair index.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            carry      <= 1'b0;
            err_sticky <= 1'b0;
            idx        <= '0;
        end else begin
            if (state == IDLE && start_in) begin
                a_sr       <= a_in;
                b_sr       <= b_in;
                res_sr     <= '0;
                carry      <= cin_in;
                err_sticky <= 1'b0;
                idx        <= '0;
            end else if (state == RUN && !abort_in) begin
                a_sr       <= a_sr >> 8;
                b_sr       <= b_sr >> 8;
                res_sr     <= res_next;
                carry      <= pair_cout;
                err_sticky <= err_sticky | pair_err;
                idx        <= idx + IDXW'(1);
            end
        end
    end

    // Result outputs update only when the final pair completes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_out  <= '0;
            cout_out <= 1'b0;
            err_out  <= 1'b0;
        end else if (finish) begin
            if (err_sticky || pair_err) begin
                sum_out  <= '0;
                cout_out <= 1'b0;
                err_out  <= 1'b1;
            end else begin
                sum_out  <= res_next;
                cout_out <= pair_cout;
                err_out  <= 1'b0;
            end
        end
    end

endmodule
